// File: rtl/alu_muldiv.sv
// Multi-cycle MUL AB / DIV AB unit: shift-add multiply, restoring divide, one bit per clock.
// Define ALU_MULDIV_EARLY_EN to let MUL finish once the unconsumed multiplier bits are zero.
module alu_muldiv #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultB,
    output logic             Carry,
    output logic             OVerflow
);

    localparam logic [3:0] ALU_MUL = 4'b1010;
    localparam logic [3:0] ALU_DIV = 4'b1011;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic               is_div;
    logic [WIDTH-1:0]   opnd;     // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]   acc;      // upper product half or partial remainder
    logic [WIDTH-1:0]   lo;       // multiplier/low product or dividend/quotient
    logic [CNT_W-1:0]   cnt;
`ifdef ALU_MULDIV_EARLY_EN
    logic [WIDTH-1:0]   mrem;     // multiplier bits not yet consumed
`endif

    logic               accept;
    logic               op_is_div;
    logic               cnt_last;
    logic               run_last;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_p;
    logic [2*WIDTH-1:0] mul_fin;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_r;
    logic [WIDTH-1:0]   div_q;

    assign op_is_div = (ALUCode == ALU_DIV);
    assign accept    = start && (ALUCode == ALU_MUL || op_is_div) && (state != RUN);
    assign cnt_last  = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_p    = {mul_sum, lo[WIDTH-1:1]};
        div_sh   = {acc, lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        div_ok   = ~div_diff[WIDTH];
        div_r    = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_q    = {lo[WIDTH-2:0], div_ok};
`ifdef ALU_MULDIV_EARLY_EN
        // Skipped iterations would only shift, so apply that shift here in one go.
        mul_fin  = mul_p >> (CNT_W'(WIDTH - 1) - cnt);
        run_last = cnt_last || (!is_div && (mrem[WIDTH-1:1] == '0));
`else
        mul_fin  = mul_p;
        run_last = cnt_last;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_div   <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            lo       <= '0;
            cnt      <= '0;
`ifdef ALU_MULDIV_EARLY_EN
            mrem     <= '0;
`endif
            busy     <= 1'b0;
            done     <= 1'b0;
            Result   <= '0;
            ResultB  <= '0;
            Carry    <= 1'b0;
            OVerflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        is_div <= op_is_div;
                        acc    <= '0;
                        cnt    <= '0;
                        opnd   <= op_is_div ? B : A;
                        lo     <= op_is_div ? A : B;
`ifdef ALU_MULDIV_EARLY_EN
                        mrem   <= B;
`endif
                        if (op_is_div && B == '0) begin
                            // Divide by zero completes at the accept edge with 8051 semantics.
                            state    <= DONE;
                            done     <= 1'b1;
                            Result   <= '1;
                            ResultB  <= A;
                            OVerflow <= 1'b1;
                            Carry    <= 1'b0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        acc <= div_r;
                        lo  <= div_q;
                    end else begin
                        acc <= mul_p[2*WIDTH-1:WIDTH];
                        lo  <= mul_p[WIDTH-1:0];
                    end
`ifdef ALU_MULDIV_EARLY_EN
                    mrem <= mrem >> 1;
`endif
                    if (run_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Carry <= 1'b0;
                        if (is_div) begin
                            Result   <= div_q;
                            ResultB  <= div_r;
                            OVerflow <= 1'b0;
                        end else begin
                            Result   <= mul_fin[WIDTH-1:0];
                            ResultB  <= mul_fin[2*WIDTH-1:WIDTH];
                            OVerflow <= |mul_fin[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: driver pushes model results, monitor pops on done.
module tb_alu_muldiv;

    localparam int W = 8;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;
    localparam logic [3:0] OP_ADD = 4'b0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   ALUCode = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, Carry, OVerflow;
    logic [W-1:0] Result, ResultB;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUCode(ALUCode), .A(A), .B(B),
        .busy(busy), .done(done), .Result(Result), .ResultB(ResultB),
        .Carry(Carry), .OVerflow(OVerflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] resb;
        logic         ov;
        int           done_cyc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [W-1:0] last_res  = '0;
    logic [W-1:0] last_resb = '0;
    logic         last_ov   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Clock edges from accept to done: bit length of B for early MUL, zero for divide-by-zero.
    function automatic int n_iter(input logic is_div, input logic [W-1:0] b);
        if (is_div) return (b == 0) ? 0 : W;
`ifdef ALU_MULDIV_EARLY_EN
        for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 1;
        return 1;
`else
        return W;
`endif
    endfunction

    function automatic exp_t model(input logic is_div, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int accept_cyc);
        exp_t e;
        logic [2*W-1:0] aa, bb, p;
        if (is_div) begin
            if (b == 0) begin
                e.res = '1; e.resb = a; e.ov = 1'b1;
            end else begin
                e.res = a / b; e.resb = a % b; e.ov = 1'b0;
            end
        end else begin
            aa = 2*W'(0) | a;
            bb = 2*W'(0) | b;
            p  = aa * bb;
            e.res  = p[W-1:0];
            e.resb = p[2*W-1:W];
            e.ov   = (p >> W) != 0;
        end
        e.done_cyc = accept_cyc + n_iter(is_div, b);
        return e;
    endfunction

    // Called right after a negedge; returns one negedge later with start dropped.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit accepted);
        exp_t e;
        start = 1'b1; ALUCode = op; A = a; B = b;
        if (accepted) begin
            e = model(op == OP_DIV, a, b, cyc + 1);
            exp_q.push_back(e);
            last_res = e.res; last_resb = e.resb; last_ov = e.ov;
        end
        @(negedge clk);
        start = 1'b0;
        ALUCode = 4'($urandom);
        A = W'($urandom);
        B = W'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL timeout: %0d results still pending, expected none", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        chk("wait_done", 32'(done), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_result"}, 32'(Result), 32'd0);
        chk({tag, "_resultb"}, 32'(ResultB), 32'd0);
        chk({tag, "_carry"}, 32'(Carry), 32'd0);
        chk({tag, "_ov"}, 32'(OVerflow), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", 32'(Result), 32'(mon_e.res));
                chk("resultb", 32'(ResultB), 32'(mon_e.resb));
                chk("overflow", 32'(OVerflow), 32'(mon_e.ov));
                chk("carry", 32'(Carry), 32'd0);
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
            end
        end
    end

    initial begin
        int r;
        logic [3:0]   op;
        logic [W-1:0] ra, rb;
        bit acc;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // MUL 0x0C*0x05: busy for exactly the iteration cycles
        issue(OP_MUL, 8'h0C, 8'h05, 1'b1);
`ifndef ALU_MULDIV_EARLY_EN
        for (int i = 0; i < W; i++) begin
            chk("mul_busy", 32'(busy), 32'd1);
            chk("mul_no_early_done", 32'(done), 32'd0);
            @(negedge clk);
        end
`endif
        wait_idle();

        // MUL overflow, then DIV started in the done cycle
        issue(OP_MUL, 8'h50, 8'hA0, 1'b1);
        wait_done();
        issue(OP_DIV, 8'hFB, 8'h12, 1'b1);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_idle();

        // Divide by zero: done right after the accept edge, never busy
        @(negedge clk);
        issue(OP_DIV, 8'h37, 8'h00, 1'b1);
        chk("div0_busy", 32'(busy), 32'd0);
        chk("div0_done", 32'(done), 32'd1);
        wait_idle();

        // Request during RUN is ignored
        @(negedge clk);
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        issue(OP_DIV, 8'h10, 8'h02, 1'b0);
        chk("run_ignore_busy", 32'(busy), 32'd1);
        wait_idle();

        // Non-MUL/DIV opcode: no busy, outputs hold
        @(negedge clk);
        issue(OP_ADD, 8'h12, 8'h34, 1'b0);
        chk("add_busy", 32'(busy), 32'd0);
        chk("add_done", 32'(done), 32'd0);
        chk("add_hold_result", 32'(Result), 32'(last_res));
        chk("add_hold_resultb", 32'(ResultB), 32'(last_resb));
        chk("add_hold_ov", 32'(OVerflow), 32'(last_ov));

        // Reset mid-DIV: everything clears, no done afterwards
        issue(OP_DIV, 8'h64, 8'h07, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_zero("midreset");
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(OP_MUL, 8'h02, 8'h03, 1'b1);
        wait_idle();

        // Short multiplier (early-termination case when enabled)
        @(negedge clk);
        issue(OP_MUL, 8'hFF, 8'h03, 1'b1);
        wait_idle();

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            r  = $urandom_range(0, 9);
            op = (r < 4) ? OP_MUL : (r < 8) ? OP_DIV : 4'($urandom);
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            acc = (op == OP_MUL) || (op == OP_DIV);
            issue(op, ra, rb, acc);
            if (!acc) chk("rand_ignored_busy", 32'(busy), 32'd0);
            else wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Multi-cycle multiply/divide companion to the combinational MCU51 ALU. It implements the MUL AB and DIV AB opcodes, generalised to WIDTH bits.
- Operands are captured on a start strobe. The unit then iterates, one bit per clock: shift-add for multiply, restoring division for divide.
- Results are held until the next accepted operation. The control unit stalls on busy and writes A/B/PSW back on done.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  operation request, sampled on rising edge.
- ALUCode  input  4  opcode; 4'b1010 = alu_mul, 4'b1011 = alu_div; other codes ignored.
- A  input  WIDTH  multiplicand / dividend.
- B  input  WIDTH  multiplier / divisor.
- busy  output  1  iteration in progress.
- done  output  1  one-cycle pulse; results valid.
- Result  output  WIDTH  product low half / quotient (written to A).
- ResultB  output  WIDTH  product high half / remainder (written to B).
- Carry  output  1  always 0 after an operation (8051 CY clear).
- OVerflow  output  1  MUL: product high half != 0. DIV: divisor == 0.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - busy=0, done=0, Result=0, ResultB=0, Carry=0, OVerflow=0, counter=0.
  - Reset mid-operation abandons the operation; no done is issued.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: one cycle, done=1.
- Accept: start=1 and ALUCode in {1010, 1011} while state is IDLE or DONE. This allows back-to-back operations: DONE->RUN directly.
- Ignored: start while RUN, and start with any other ALUCode. Neither causes a state change nor any output change.
- On accept at edge E0:
  - Latch A, B and the operation.
  - Clear the accumulator/remainder; counter=0.
  - Go to RUN; busy=1 from E0.
- MUL iteration: if multiplier LSB=1, add the multiplicand into the upper accumulator (WIDTH+1 bits to keep the carry). Then shift {carry, accumulator, multiplier} right by 1.
- DIV iteration: shift {remainder, dividend} left by 1. Trial-subtract the divisor from the remainder (WIDTH+1 bits). If non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
- RUN lasts exactly WIDTH cycles. At edge E_WIDTH:
  - Register Result/ResultB/OVerflow; Carry=0.
  - Go to DONE; busy=0, done=1 for one cycle.
- After DONE, go to IDLE unless a new accept occurs. Outputs hold until the next DONE.
- DIV with B==0 at accept:
  - No iteration; go straight to DONE at E0, so done is high in the cycle after the start edge.
  - Result={WIDTH{1'b1}}, ResultB=A, OVerflow=1, Carry=0.
- MUL with either operand 0 still takes the full WIDTH cycles (unless the optional feature is enabled). Result=0, ResultB=0, OV=0.
- Operand inputs may change freely after the accept edge; only the latched copies are used.
- Outputs are registered. There is no combinational path from the inputs to any output.

Optional Feature:
- Macro ALU_MULDIV_EARLY_EN.
- Defined: MUL terminates early once the remaining (shifted) multiplier bits are all zero after the current iteration.
  - Minimum 1 iteration. The product is still correctly aligned: the remaining shift is applied in the final cycle.
  - DIV latency is unchanged.
- Undefined: MUL always takes WIDTH cycles. Latency is deterministic at WIDTH for both MUL and non-zero DIV.

Test Plan:
- WIDTH=8, MUL A=0x0C B=0x05 -> Result=0x3C, ResultB=0x00, OV=0, Carry=0. done exactly 8 clocks after the start edge; busy high for those 8.
- MUL A=0x50 B=0xA0 -> Result=0x00, ResultB=0x32, OV=1, Carry=0. Then back-to-back DIV A=0xFB B=0x12, with start asserted during the done cycle -> Result=0x0D, ResultB=0x11, OV=0.
- DIV A=0x37 B=0x00 -> done the cycle after start, Result=0xFF, ResultB=0x37, OV=1, busy never asserted.
- Start MUL A=0xFF B=0xFF; pulse start with DIV A=0x10 B=0x02 at cycle 3 of RUN -> second request ignored; result 0xFE01 (Result=0x01, ResultB=0xFE, OV=1). Then start with ALUCode=alu_add -> no busy, outputs unchanged.
- Start DIV A=0x64 B=0x07; drive rst_n=0 at cycle 4 -> all outputs 0 next edge, no done pulse. A new MUL 0x02*0x03 after reset -> Result=0x06.
- With ALU_MULDIV_EARLY_EN: MUL A=0xFF B=0x03 -> done 2 clocks after start, Result=0xFD, ResultB=0x02, OV=1. The same stimulus without the macro -> identical values after 8 clocks.
